// File: rtl/acc_stage_if.sv
// Valid/stall stream bundle shared by both sides of acc_stage.
// 'tag' carries last on the upstream side and the group overflow flag downstream.
interface acc_stage_if #(
  parameter int WIDTH = 32
);
  logic             v;
  logic [WIDTH-1:0] data;
  logic             tag;
  logic             stall;

  modport master (output v, data, tag, input stall);
  modport slave  (input v, data, tag, output stall);
endinterface

// File: rtl/acc_stage.sv
// Group accumulator: sums COUNT words (or up to last) and emits one registered total.
// Define ACC_SAT_EN for unsigned saturating accumulation; default wraps modulo 2^WIDTH.
module acc_stage #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  acc_stage_if.slave  up,
  acc_stage_if.master dn
);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic             ovf_r;
  logic             v_r;
  logic [WIDTH-1:0] data_r;
  logic             ovf_r_o;

  logic             out_free;
  logic             accept;
  logic             close;
  logic [WIDTH:0]   sum_full;
  logic             grp_ovf;
  logic [WIDTH-1:0] sum_st;

  always_comb begin
    out_free = ~v_r | ~dn.stall;
    accept   = up.v & out_free;
    sum_full = {1'b0, acc_r} + {1'b0, up.data};
    grp_ovf  = ovf_r | sum_full[WIDTH];
`ifdef ACC_SAT_EN
    // Once the group has overflowed, pin the running sum at full scale.
    sum_st   = grp_ovf ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    sum_st   = sum_full[WIDTH-1:0];
`endif
    close    = accept & (up.tag | (cnt_r == CNT_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      acc_r   <= '0;
      ovf_r   <= 1'b0;
      v_r     <= 1'b0;
      data_r  <= '0;
      ovf_r_o <= 1'b0;
    end else begin
      if (close) begin
        acc_r   <= '0;
        ovf_r   <= 1'b0;
        cnt_r   <= '0;
        v_r     <= 1'b1;
        data_r  <= sum_st;
        ovf_r_o <= grp_ovf;
      end else begin
        if (accept) begin
          acc_r <= sum_st;
          ovf_r <= grp_ovf;
          cnt_r <= cnt_r + 1'b1;
        end
        // A stalled total holds; an unstalled one is consumed this edge.
        if (!dn.stall)
          v_r <= 1'b0;
      end
    end
  end

  assign up.stall = ~out_free;
  assign dn.v     = v_r;
  assign dn.data  = data_r;
  assign dn.tag   = ovf_r_o;
endmodule

// File: tb/tb_acc_stage.sv
// Directed bench for acc_stage: COUNT=4 and COUNT=1 instances, WIDTH=32.
module tb_acc_stage;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  acc_stage_if #(.WIDTH(32)) up4 ();
  acc_stage_if #(.WIDTH(32)) dn4 ();
  acc_stage_if #(.WIDTH(32)) up1 ();
  acc_stage_if #(.WIDTH(32)) dn1 ();

  acc_stage #(.WIDTH(32), .COUNT(4)) dut4 (.clk(clk), .reset(reset), .up(up4), .dn(dn4));
  acc_stage #(.WIDTH(32), .COUNT(1)) dut1 (.clk(clk), .reset(reset), .up(up1), .dn(dn1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word to the COUNT=4 instance for one edge, then drop valid.
  task automatic send4(input logic [31:0] d, input logic l);
    up4.v = 1'b1; up4.data = d; up4.tag = l;
    tick();
    up4.v = 1'b0; up4.tag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (dn4.v !== 1'b0 || dn4.data !== 32'd0 || dn4.tag !== 1'b0 || up4.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset4: v=%0b data=%0h ovf=%0b stall=%0b required all 0", dn4.v, dn4.data, dn4.tag, up4.stall);
    end
    checks++;
    if (dn1.v !== 1'b0 || dn1.data !== 32'd0 || dn1.tag !== 1'b0 || up1.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset1: v=%0b data=%0h ovf=%0b stall=%0b required all 0", dn1.v, dn1.data, dn1.tag, up1.stall);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] w [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 4; i++) begin
      send4(w[i], 1'b0);
      if (i < 3) begin
        checks++;
        if (dn4.v !== 1'b0 || up4.stall !== 1'b0) begin
          errors++;
          $display("FAIL basic_mid%0d: v=%0b stall=%0b required v=0 stall=0", i, dn4.v, up4.stall);
        end
      end
    end
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== 32'd10 || dn4.tag !== 1'b0 || up4.stall !== 1'b0) begin
      errors++;
      $display("FAIL basic_total: v=%0b data=%0d ovf=%0b stall=%0b required v=1 data=10 ovf=0 stall=0",
               dn4.v, dn4.data, dn4.tag, up4.stall);
    end
    tick();
    checks++;
    if (dn4.v !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: v=%0b required 0", dn4.v);
    end
    $display("test_basic done");
  endtask

  task automatic test_early_close();
    send4(32'd5, 1'b0);
    send4(32'd7, 1'b1);
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== 32'd12 || dn4.tag !== 1'b0) begin
      errors++;
      $display("FAIL early_total: v=%0b data=%0d ovf=%0b required v=1 data=12 ovf=0", dn4.v, dn4.data, dn4.tag);
    end
    for (int i = 0; i < 4; i++) send4(32'd1, 1'b0);
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== 32'd4 || dn4.tag !== 1'b0) begin
      errors++;
      $display("FAIL early_next: v=%0b data=%0d ovf=%0b required v=1 data=4 ovf=0", dn4.v, dn4.data, dn4.tag);
    end
    tick();
    $display("test_early_close done");
  endtask

  task automatic test_backpressure();
    // Downstream stalled but output empty: the whole group is still accepted.
    dn4.stall = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (up4.stall !== 1'b0) begin
        errors++;
        $display("FAIL bp_accept%0d: stall_o=%0b required 0", i, up4.stall);
      end
      send4(32'(i), 1'b0);
    end
    up4.v = 1'b1; up4.data = 32'd1; up4.tag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (up4.stall !== 1'b1 || dn4.v !== 1'b1 || dn4.data !== 32'd10 || dn4.tag !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: stall_o=%0b v=%0b data=%0d ovf=%0b required stall_o=1 v=1 data=10 ovf=0",
                 c, up4.stall, dn4.v, dn4.data, dn4.tag);
      end
      tick();
    end
    dn4.stall = 1'b0;
    #1;
    checks++;
    if (up4.stall !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: stall_o=%0b required 0", up4.stall);
    end
    send4(32'd1, 1'b0);
    checks++;
    if (dn4.v !== 1'b0) begin
      errors++;
      $display("FAIL bp_consumed: v=%0b required 0", dn4.v);
    end
    for (int i = 0; i < 3; i++) send4(32'd1, 1'b0);
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== 32'd4) begin
      errors++;
      $display("FAIL bp_total: v=%0b data=%0d required v=1 data=4", dn4.v, dn4.data);
    end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_overflow();
    logic [31:0] exp_data;
`ifdef ACC_SAT_EN
    exp_data = 32'hFFFF_FFFF;
`else
    exp_data = 32'h0000_0001;
`endif
    send4(32'hFFFF_FFFF, 1'b0);
    send4(32'd2, 1'b0);
    send4(32'd0, 1'b0);
    send4(32'd0, 1'b0);
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== exp_data || dn4.tag !== 1'b1) begin
      errors++;
      $display("FAIL overflow: v=%0b data=%08h ovf=%0b required v=1 data=%08h ovf=1",
               dn4.v, dn4.data, dn4.tag, exp_data);
    end
    // Next group must start with a clean overflow flag.
    for (int i = 0; i < 4; i++) send4(32'd2, 1'b0);
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== 32'd8 || dn4.tag !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: v=%0b data=%0d ovf=%0b required v=1 data=8 ovf=0", dn4.v, dn4.data, dn4.tag);
    end
    tick();
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid();
    send4(32'd3, 1'b0);
    send4(32'd4, 1'b0);
    reset = 1'b1;
    tick();
    checks++;
    if (dn4.v !== 1'b0 || dn4.data !== 32'd0 || dn4.tag !== 1'b0 || up4.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: v=%0b data=%0d ovf=%0b stall=%0b required all 0",
               dn4.v, dn4.data, dn4.tag, up4.stall);
    end
    reset = 1'b0;
    send4(32'd1, 1'b0);
    // last without valid must not close the group.
    up4.tag = 1'b1;
    tick();
    up4.tag = 1'b0;
    checks++;
    if (dn4.v !== 1'b0) begin
      errors++;
      $display("FAIL last_no_valid: v=%0b required 0", dn4.v);
    end
    for (int i = 0; i < 3; i++) send4(32'd1, 1'b0);
    checks++;
    if (dn4.v !== 1'b1 || dn4.data !== 32'd4) begin
      errors++;
      $display("FAIL reset_mid_total: v=%0b data=%0d required v=1 data=4", dn4.v, dn4.data);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_count1();
    up1.v = 1'b1; up1.data = 32'd9; up1.tag = 1'b0;
    tick();
    checks++;
    if (dn1.v !== 1'b1 || dn1.data !== 32'd9 || dn1.tag !== 1'b0) begin
      errors++;
      $display("FAIL count1_first: v=%0b data=%0h ovf=%0b required v=1 data=9 ovf=0", dn1.v, dn1.data, dn1.tag);
    end
    up1.data = 32'hA;
    tick();
    up1.v = 1'b0;
    checks++;
    if (dn1.v !== 1'b1 || dn1.data !== 32'hA || dn1.tag !== 1'b0) begin
      errors++;
      $display("FAIL count1_second: v=%0b data=%0h ovf=%0b required v=1 data=a ovf=0", dn1.v, dn1.data, dn1.tag);
    end
    tick();
    checks++;
    if (dn1.v !== 1'b0) begin
      errors++;
      $display("FAIL count1_idle: v=%0b required 0", dn1.v);
    end
    $display("test_count1 done");
  endtask

  initial begin
    reset = 1'b1;
    up4.v = 1'b0; up4.data = '0; up4.tag = 1'b0; dn4.stall = 1'b0;
    up1.v = 1'b0; up1.data = '0; up1.tag = 1'b0; dn1.stall = 1'b0;
    test_reset();
    test_basic();
    test_early_close();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_count1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
